dm_store_buffer: RTL and testbench
==================================

Name: dm_store_buffer

Overview:
- Word-granular store buffer between the MEM-stage request (from the EX/MEM pipeline register) and the single-port data memory.
- Stores are queued and drained to memory on cycles when the memory port is free.
- Loads use the port immediately and get store-to-load forwarding from the buffer.
- Keeps the memory port single-address (one read or one write per cycle) while MEM-stage stores complete in one cycle in the common case.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- CW, 3, width of the count output; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_load  in  1  MEM stage issues a word load this cycle.
- req_store  in  1  MEM stage issues a word store this cycle.
- req_addr  in  32  byte address of the request; bits [1:0] ignored.
- req_wdata  in  32  store data.
- req_pc  in  32  PC of the requesting instruction.
- load_data  out  32  load result; combinational.
- stall  out  1  store not accepted this cycle; upstream holds the request.
- dm_wr  out  1  memory write enable.
- dm_a  out  32  memory address.
- dm_wd  out  32  memory write data.
- dm_pc  out  32  PC of the store being drained (for the memory write log).
- dm_rdata  in  32  memory read data; combinational from dm_a.
- count  out  CW  number of valid entries.
- empty  out  1  count==0.

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr[31:2], data, pc}. head = oldest, tail = next free slot. Pointers wrap modulo DEPTH.
- Reset (rst high at posedge): head=tail=count=0; entry contents don't care. While rst is high, dm_wr=0 and stall=0 regardless of other inputs.
- Port arbitration is combinational each cycle, in priority order:
  - (a) req_load=1: dm_a=req_addr, dm_wr=0, no drain.
  - (b) else if count>0 and (req_store=0 or count==DEPTH): drain. dm_wr=1, dm_a={head.addr,2'b00}, dm_wd=head.data, dm_pc=head.pc; head advances and count decrements at posedge.
  - (c) else: dm_wr=0, dm_a=req_addr.
- dm_wd and dm_pc are 0 when not draining.
- Load forwarding:
  - load_data = data of the youngest valid entry whose addr[31:2] equals req_addr[31:2]; otherwise dm_rdata.
  - Youngest means closest to tail, searched with wrap-around.
  - Zero-cycle latency (combinational).
- Store acceptance:
  - Enqueued at posedge when req_store=1, req_load=0, and count<DEPTH.
  - Write {req_addr[31:2], req_wdata, req_pc} at tail; tail advances.
  - Else if req_store=1, stall=1.
- Full case: req_store=1 with count==DEPTH → stall=1 and a drain occurs the same cycle. The next cycle has count=DEPTH-1 and the held store is accepted. Exactly one stall cycle.
- Store with no drain (count<DEPTH, rule (c)) → count+1. A store with a drain is only possible when full, so count never changes by more than 1 per cycle.
- req_load and req_store both high (illegal): load served, stall=1, store not accepted, no drain.
- Duplicate addresses are allowed in the buffer. Drain order is FIFO, so memory ends with the youngest value. Forwarding always returns the youngest value.
- rst asserted mid-operation: buffered stores are discarded and never written.
- Idle cycles (no request) drain one entry per cycle until empty.

Test Plan:
- Reset, then 3 stores (A=0x0,0x4,0x8; D=0x11,0x22,0x33) on consecutive cycles, then idle → count=3 after the stores; dm_wr=1 for 3 idle cycles with dm_a 0x0, 0x4, 0x8 in order; empty=1 after.
- Store 0x10←0xAAAA, store 0x10←0xBBBB, then load 0x10 → load_data=0xBBBB; dm_wr=0 on the load cycle; after drain, memory[0x10]=0xBBBB.
- Load 0x20 with dm_rdata=0x1234 and no matching entry → load_data=0x1234, dm_a=0x20.
- Fill 4 stores, then a 5th store (0x40←0x55) → stall=1 for exactly 1 cycle; dm_wr=1 with dm_a = first store's address; next cycle accepted, count=4.
- Wrap: 6 stores interleaved with idles so tail wraps past index 3; then load the address of the 6th store → forwarded data correct; drain order matches issue order.
- 2 stores queued, rst high one cycle, then idle → count=0, dm_wr never asserted after reset.

Source files
------------

// File: rtl/dm_store_buffer_if.sv
// Bundle between the MEM stage, the store buffer and the single-port data memory.
// The slave side is the store buffer. The master side is the pipeline together with the memory.
interface dm_store_buffer_if;
  logic        req_load;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [31:0] load_data;
  logic        stall;
  logic        dm_wr;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  modport master (
    output req_load, req_store, req_addr, req_wdata, req_pc, dm_rdata,
    input  load_data, stall, dm_wr, dm_a, dm_wd, dm_pc
  );

  modport slave (
    input  req_load, req_store, req_addr, req_wdata, req_pc, dm_rdata,
    output load_data, stall, dm_wr, dm_a, dm_wd, dm_pc
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Word-granular store buffer that queues stores and drains them when the memory port is idle.
// Loads take the port at once and are forwarded from the youngest matching buffered store.
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  dm_store_buffer_if.slave    bus,
  output logic [CW-1:0]       count,
  output logic                empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;

  logic full, drain, accept;

  assign full   = (count_q == FullCount);
  assign drain  = !rst && !bus.req_load && (count_q != '0) && (!bus.req_store || full);
  assign accept = !rst && bus.req_store && !bus.req_load && !full;

  assign bus.stall = !rst && bus.req_store && !accept;
  assign bus.dm_wr = drain;
  assign bus.dm_a  = drain ? {addr_q[head_q], 2'b00} : bus.req_addr;
  assign bus.dm_wd = drain ? data_q[head_q] : 32'h0;
  assign bus.dm_pc = drain ? pc_q[head_q] : 32'h0;

  assign count = count_q;
  assign empty = (count_q == '0);

  // Walk oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    logic [PW-1:0] idx;
    idx           = head_q;
    bus.load_data = bus.dm_rdata;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == bus.req_addr[31:2])) begin
        bus.load_data = data_q[idx];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (accept && !drain) begin
      count_d = count_q + 1'b1;
    end else if (drain && !accept) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) tail_q <= tail_q + 1'b1;
      if (drain)  head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail_q] <= bus.req_addr[31:2];
      data_q[tail_q] <= bus.req_wdata;
      pc_q[tail_q]   <= bus.req_pc;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: vector table, hand sequences and a drain scoreboard.
module tb_dm_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_store_buffer_if bus ();
  logic [CW-1:0] count;
  logic          empty;

  dm_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .empty (empty)
  );

  logic [31:0] mem [256];
  assign bus.dm_rdata = mem[bus.dm_a[9:2]];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        r, ld, st;
    logic [31:0] addr, wdata;
    logic        e_stall, e_wr;
    logic [31:0] e_a;
    logic        ck_ld;
    logic [31:0] e_ld;
    logic        ck_cnt;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t vecs[18];

  int n_chk  = 0;
  int n_pass = 0;

  logic        o_stall, o_wr;
  logic [31:0] o_a, o_ld, o_cnt;

  function automatic logic [31:0] pc_of(input logic [31:0] a, input logic [31:0] d);
    return 32'h0040_0000 + a + (d << 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  // One cycle: drive at negedge, sample 1ns later, update scoreboard and memory model.
  task automatic step(input logic r, input logic ld, input logic st,
                      input logic [31:0] a, input logic [31:0] d);
    sb_t e;
    @(negedge clk);
    rst           = r;
    bus.req_load  = ld;
    bus.req_store = st;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_pc    = pc_of(a, d);
    #1;
    o_stall = bus.stall;
    o_wr    = bus.dm_wr;
    o_a     = bus.dm_a;
    o_ld    = bus.load_data;
    o_cnt   = 32'(count);
    if (r) begin
      sb_q.delete();
    end else begin
      if (o_wr) begin
        if (sb_q.size() == 0) begin
          chk("sb_spurious_wr", 32'(o_wr), 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_addr", bus.dm_a, e.addr);
          chk("sb_data", bus.dm_wd, e.data);
          chk("sb_pc", bus.dm_pc, e.pc);
          mem[bus.dm_a[9:2]] = bus.dm_wd;
        end
      end else if (bus.dm_wd != 32'h0 || bus.dm_pc != 32'h0) begin
        chk("idle_wd_pc_zero", bus.dm_wd | bus.dm_pc, 32'h0);
      end
      if (st && !ld && !o_stall) sb_q.push_back({a & 32'hFFFF_FFFC, d, pc_of(a, d)});
    end
  endtask

  task automatic drain_all(input string name);
    for (int k = 0; k < 20 && count != '0; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({name, "_count"}, 32'(count), 32'h0);
    chk({name, "_empty"}, 32'(empty), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'h0000_1234;
    rst = 1'b1;
    bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_pc = '0;

    //          r     ld    st    addr          wdata         stall wr    dm_a          ckld  ld_data       ckc   cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h100, 32'h0,      1'b0, 1'b0, 32'h100, 1'b0, 32'h0,      1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h0,      1'b0, 1'b0, 32'h0,   1'b0, 32'h0,      1'b1, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,   32'h11,     1'b0, 1'b0, 32'h0,   1'b0, 32'h0,      1'b1, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h4,   32'h22,     1'b0, 1'b0, 32'h4,   1'b0, 32'h0,      1'b1, 32'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h8,   32'h33,     1'b0, 1'b0, 32'h8,   1'b0, 32'h0,      1'b1, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,      1'b0, 1'b1, 32'h0,   1'b0, 32'h0,      1'b1, 32'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,      1'b0, 1'b1, 32'h4,   1'b0, 32'h0,      1'b1, 32'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,      1'b0, 1'b1, 32'h8,   1'b0, 32'h0,      1'b1, 32'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,      1'b0, 1'b0, 32'h0,   1'b0, 32'h0,      1'b1, 32'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h10,  32'hAAAA,   1'b0, 1'b0, 32'h10,  1'b0, 32'h0,      1'b1, 32'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h10,  32'hBBBB,   1'b0, 1'b0, 32'h10,  1'b0, 32'h0,      1'b1, 32'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h10,  32'h0,      1'b0, 1'b0, 32'h10,  1'b1, 32'hBBBB,   1'b1, 32'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,      1'b0, 1'b1, 32'h10,  1'b0, 32'h0,      1'b1, 32'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,      1'b0, 1'b1, 32'h10,  1'b0, 32'h0,      1'b1, 32'd1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h10,  32'h0,      1'b0, 1'b0, 32'h10,  1'b1, 32'hBBBB,   1'b1, 32'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h20,  32'h0,      1'b0, 1'b0, 32'h20,  1'b1, 32'h1234,   1'b1, 32'd0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h24,  32'h99,     1'b1, 1'b0, 32'h24,  1'b1, 32'h0,      1'b1, 32'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h24,  32'h0,      1'b0, 1'b0, 32'h24,  1'b0, 32'h0,      1'b1, 32'd0};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_stall", i), 32'(o_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_dm_wr", i), 32'(o_wr), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_dm_a", i), o_a, vecs[i].e_a);
      if (vecs[i].ck_ld) chk($sformatf("v%0d_load_data", i), o_ld, vecs[i].e_ld);
      if (vecs[i].ck_cnt) begin
        chk($sformatf("v%0d_count", i), o_cnt, vecs[i].e_cnt);
        chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_cnt == 0));
      end
    end

    // Full buffer: one stall cycle with a same-cycle drain, then the held store goes in.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h30 + 32'(4 * i), 32'(i + 1));
      chk("fill_stall", 32'(o_stall), 32'h0);
    end
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'h55);
    chk("full_stall", 32'(o_stall), 32'h1);
    chk("full_dm_wr", 32'(o_wr), 32'h1);
    chk("full_dm_a", o_a, 32'h30);
    chk("full_count", o_cnt, 32'd4);
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'h55);
    chk("retry_stall", 32'(o_stall), 32'h0);
    chk("retry_dm_wr", 32'(o_wr), 32'h0);
    chk("retry_count", o_cnt, 32'd3);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("after_retry_count", o_cnt, 32'd4);
    chk("after_retry_dm_a", o_a, 32'h34);
    drain_all("full_drain");

    // Wrap: six stores with idles; the sixth reuses the second's address.
    step(1'b0, 1'b0, 1'b1, 32'h60, 32'h601);
    step(1'b0, 1'b0, 1'b1, 32'h64, 32'h602);
    step(1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h68, 32'h603);
    step(1'b0, 1'b0, 1'b1, 32'h6C, 32'h604);
    step(1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h70, 32'h605);
    step(1'b0, 1'b0, 1'b1, 32'h64, 32'h606);
    chk("wrap_last_stall", 32'(o_stall), 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h64, 32'h0);
    chk("wrap_fwd_youngest", o_ld, 32'h606);
    chk("wrap_count", o_cnt, 32'd4);
    chk("wrap_load_no_wr", 32'(o_wr), 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h68, 32'h0);
    chk("wrap_fwd_mid", o_ld, 32'h603);
    drain_all("wrap_drain");
    step(1'b0, 1'b1, 1'b0, 32'h64, 32'h0);
    chk("wrap_mem_youngest", o_ld, 32'h606);
    step(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
    chk("wrap_mem_first", o_ld, 32'h601);

    // Reset mid-operation discards buffered stores.
    step(1'b0, 1'b0, 1'b1, 32'h80, 32'h801);
    step(1'b0, 1'b0, 1'b1, 32'h84, 32'h802);
    step(1'b1, 1'b0, 1'b0, 32'h0,  32'h0);
    chk("rst_dm_wr", 32'(o_wr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("post_rst_dm_wr", 32'(o_wr), 32'h0);
      chk("post_rst_count", o_cnt, 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
    chk("post_rst_mem", o_ld, 32'h0);

    chk("sb_leftover", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
